// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined barrel shifter (sll / srl / sra / rol) with a
// valid/ready handshake on both sides. One pipeline stage per shift-amount
// bit; stage k shifts by 2^(SW-1-k) when its shift-amount bit is set.
// The whole pipeline advances together and freezes while the output holds
// an unaccepted result.
// Optional feature: define PIPE_SHIFTER_ROTATE_EN to enable rotate-left on
// in_op=11. Without it, in_op=11 is a plain logical left shift and no
// wrap-around logic exists.
module pipe_shifter #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Global advance: every stage moves unless the output is blocked. Bubbles
  // travel like real entries, so in_ready is simply this term.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_stage
      localparam int AMT = 1 << (SW - 1 - gi);

      logic [WIDTH-1:0] src_data;
      logic [1:0]       src_op;
      logic             src_valid;
      logic             src_bit;
      logic [WIDTH-1:0] shifted;
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;

      // Stage 0 takes the operand straight from the input port; later stages
      // take the previous stage's registers.
      if (gi == 0) begin : g_src
        assign src_data  = in_data;
        assign src_op    = in_op;
        assign src_valid = in_valid;
        assign src_bit   = in_shamt[SW-1];
      end else begin : g_src
        assign src_data  = g_stage[gi-1].data_reg;
        assign src_op    = g_stage[gi-1].g_fwd.op_reg;
        assign src_valid = g_stage[gi-1].valid_reg;
        assign src_bit   = g_stage[gi-1].g_fwd.shamt_reg[SW-1-gi];
      end

      // Fixed-distance shift for this stage; sra fill uses the operand sign,
      // which right shifts never disturb.
      always_comb begin
        shifted = {src_data[WIDTH-1-AMT:0], {AMT{1'b0}}};
        case (src_op)
          2'b01:   shifted = {{AMT{1'b0}}, src_data[WIDTH-1:AMT]};
          2'b10:   shifted = {{AMT{src_data[WIDTH-1]}}, src_data[WIDTH-1:AMT]};
`ifdef PIPE_SHIFTER_ROTATE_EN
          2'b11:   shifted = {src_data[WIDTH-1-AMT:0], src_data[WIDTH-1:WIDTH-AMT]};
`endif
          default: shifted = {src_data[WIDTH-1-AMT:0], {AMT{1'b0}}};
        endcase
      end

      // Data and valid register; in-flight entries are dropped on reset.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (advance) begin
          valid_reg <= src_valid;
          data_reg  <= src_bit ? shifted : src_data;
        end
      end

      // Op and the not-yet-consumed shift bits only travel as far as a later
      // stage needs them; the final stage has nothing left to consume.
      if (gi < SW - 1) begin : g_fwd
        localparam int RW = SW - 1 - gi;
        logic [1:0]    op_reg;
        logic [RW-1:0] shamt_reg;
        logic [RW-1:0] rem_bits;

        if (gi == 0) begin : g_rem
          assign rem_bits = in_shamt[RW-1:0];
        end else begin : g_rem
          assign rem_bits = g_stage[gi-1].g_fwd.shamt_reg[RW-1:0];
        end

        // Forward op and remaining shift-amount bits alongside the data.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            op_reg    <= '0;
            shamt_reg <= '0;
          end else if (advance) begin
            op_reg    <= src_op;
            shamt_reg <= rem_bits;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[SW-1].valid_reg;
  assign out_data  = g_stage[SW-1].data_reg;
  assign out_zero  = out_valid && (out_data == '0);

endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: directed vectors with hand-computed results. Expected
// results go into a queue when an input is accepted; a monitor pops and
// compares on every output transfer. A second WIDTH=8 instance checks the
// short-pipeline case. Rotate expectations follow PIPE_SHIFTER_ROTATE_EN.
module tb_pipe_shifter;
  localparam int W = 32;
  localparam int S = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [W-1:0] in_data, out_data;
  logic [S-1:0] in_shamt;
  logic [1:0]   in_op;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_in_shamt;
  logic [1:0] b_in_op;

  int checks = 0;
  int errors = 0;
  int results = 0;
  logic [W-1:0] exp_q[$];

  pipe_shifter #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero)
  );

  pipe_shifter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_zero(b_out_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding result.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%08h, expected no result", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        results++;
        $display("result %0d: data=0x%08h zero=%0b expected=0x%08h", results, out_data, out_zero, e);
        check("out_data", out_data, e);
        check("out_zero", out_zero, e == '0);
      end
    end
  end

  // Offer one operand until accepted; queue its result on the accepting edge.
  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                      input logic [31:0] e);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
    end
    if (ok) exp_q.push_back(e);
    else check("send_timeout", 0, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clock);
      #2;
    end
    check(name, exp_q.size(), 0);
  endtask

  // WIDTH=8 instance: accepted on one edge, valid exactly 3 edges later.
  task automatic send8(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] op,
                       input logic [7:0] e);
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_shamt = sh;
    b_in_op    = op;
    @(negedge clock);
    check("w8_in_ready", b_in_ready, 1);
    @(posedge clock);
    #1 b_in_valid = 1'b0;
    @(posedge clock); #1;
    check("w8_not_yet_valid", b_out_valid, 0);
    @(posedge clock); #1;
    check("w8_valid_at_3", b_out_valid, 1);
    check("w8_data", b_out_data, e);
    $display("w8 result: data=0x%02h expected=0x%02h", b_out_data, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] rol_a, rol_b;
    logic [7:0]   rol8;
    bit seen;
`ifdef PIPE_SHIFTER_ROTATE_EN
    rol_a = 32'h0000_0003;
    rol_b = 32'h3456_7812;
    rol8  = 8'h18;
`else
    rol_a = 32'h0000_0002;
    rol_b = 32'h3456_7800;
    rol8  = 8'h10;
`endif
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_w8_out_valid", b_out_valid, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Latency: valid exactly 5 edges after (and counting) the accepting edge
    send(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    repeat (S - 2) @(posedge clock);
    #1 check("lat_not_yet_valid", out_valid, 0);
    @(posedge clock);
    #1 check("lat_valid_at_5", out_valid, 1);
    drain("drain_latency");

    // Directed vectors, back to back
    send(32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);
    send(32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
    send(32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000);
    send(32'h8000_0001, 5'd1,  2'b11, rol_a);
    send(32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF);
    send(32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001);
    send(32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800);
    send(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    send(32'h1234_5678, 5'd8,  2'b11, rol_b);
    send(32'h4000_0000, 5'd30, 2'b10, 32'h0000_0001);
    send(32'hFFFF_FFFF, 5'd16, 2'b00, 32'hFFFF_0000);
    drain("drain_vectors");

    // Back-pressure: 8 back-to-back operands, output stalled for 4 cycles
    fork
      begin
        for (int k = 0; k < 8; k++) send(32'h1, 5'(k), 2'b00, 32'h1 << k);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clock);
          seen = out_valid;
        end
        if (!seen) check("stall_wait_valid", 0, 1);
        repeat (2) @(posedge clock);
        #1 out_ready = 1'b0;
        held = '0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clock);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          if (c == 0) held = out_data;
          else check("stall_hold", out_data, held);
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");
    check("stall_result_count", results, 1 + 14 + 8);

    // WIDTH=8 instance
    send8(8'h81, 3'd0, 2'b00, 8'h81);
    send8(8'h80, 3'd7, 2'b10, 8'hFF);
    send8(8'h81, 3'd4, 2'b11, rol8);

    // Reset mid-stream with three results in flight
    send(32'h0000_0011, 5'd0, 2'b00, 32'h0000_0011);
    send(32'h0000_0022, 5'd1, 2'b00, 32'h0000_0044);
    send(32'h0000_0033, 5'd2, 2'b00, 32'h0000_00CC);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = out_valid;
    end
    if (!seen) check("rst_wait_valid", 0, 1);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      seen = seen | out_valid;
    end
    check("no_stale_after_reset", seen, 0);

    // Pipeline works normally after reset
    send(32'h0000_00A5, 5'd4, 2'b00, 32'h0000_0A50);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width; power of two, 8..64.
REQ-002 The block SHALL have derived parameter SW = log2(WIDTH), default 5: shift-amount width and pipeline depth.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state on rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: input operand valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept an input this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: operand.
REQ-008 The block SHALL have port in_shamt, input, SW bits: shift amount, unsigned.
REQ-009 The block SHALL have port in_op, input, 2 bits: 00 sll, 01 srl, 10 sra, 11 rol.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: shifted result.
REQ-013 The block SHALL have port out_zero, output, 1 bit: high when out_data is all zeros, qualified by out_valid.

Function
REQ-014 The block SHALL transfer an input when in_valid and in_ready are both high on a rising edge.
REQ-015 The block SHALL transfer an output when out_valid and out_ready are both high on a rising edge.
REQ-016 The block SHALL implement SW pipeline stages; stage k (k=0..SW-1) conditionally shifts by 2^(SW-1-k) under in_shamt bit SW-1-k.
REQ-017 Each stage SHALL register data, remaining shamt bits, op and a valid bit.
REQ-018 Latency from input transfer to out_valid SHALL be exactly SW cycles (5 at WIDTH=32) when not stalled.
REQ-019 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-020 Vacated bit fill SHALL be: sll zeros at LSBs; srl zeros at MSBs; sra copies of operand bit WIDTH-1; rol bits wrapped from MSB to LSB.
REQ-021 A shamt of 0 SHALL return in_data unchanged for every op.
REQ-022 in_ready SHALL equal (!out_valid || out_ready); the block is combinational in this term, with no registered ready.
REQ-023 While out_valid && !out_ready, all stages SHALL hold their contents and out_data SHALL remain stable.
REQ-024 Bubbles (invalid stages) SHALL advance normally when the pipeline is not stalled; no bubble collapsing.
REQ-025 Results SHALL emerge in input-transfer order; none SHALL be dropped or duplicated.
REQ-026 out_zero SHALL be computed from the final stage register, with no extra latency.

Reset
REQ-027 Assertion of reset_n low SHALL immediately clear all stage valid bits, out_valid and out_data to 0, independent of clock.
REQ-028 Data in flight at reset SHALL be discarded; no result SHALL appear after reset release without a new input transfer.
REQ-029 in_ready SHALL be 1 during and after reset.
REQ-030 Inputs SHALL first be accepted on the first rising edge with reset_n high.

Configuration
REQ-031 The block SHALL use macro PIPE_SHIFTER_ROTATE_EN to control rotate support.
REQ-032 With PIPE_SHIFTER_ROTATE_EN defined, in_op=11 SHALL perform rotate-left per REQ-020.
REQ-033 Without PIPE_SHIFTER_ROTATE_EN, in_op=11 SHALL behave exactly as sll, and no wrap-around logic SHALL be synthesised.

Verification
REQ-034 The bench SHALL cover: WIDTH=32, sll 0x00000001 shamt 31 -> out_data 0x80000000, out_valid exactly 5 cycles after transfer.
REQ-035 The bench SHALL cover: srl 0x80000000 shamt 4 -> 0x08000000; sra 0x80000000 shamt 4 -> 0xF8000000; sra 0x7FFFFFFF shamt 31 -> 0x00000000 with out_zero=1.
REQ-036 The bench SHALL cover: rol 0x80000001 shamt 1 -> 0x00000003 with PIPE_SHIFTER_ROTATE_EN defined; the same stimulus -> 0x00000002 without it.
REQ-037 The bench SHALL cover: 8 back-to-back inputs with out_ready=0 from cycle 3 for 4 cycles -> in_ready=0 while stalled, out_data held stable, all 8 results in order, none lost.
REQ-038 The bench SHALL cover: reset_n pulsed low mid-stream with 3 results in flight -> out_valid=0 immediately, and no stale result after release.
REQ-039 The bench SHALL cover: WIDTH=8, sll 0x81 shamt 0 -> 0x81 after 3 cycles.
